// File: rtl/alu_control.sv
// ---------------------------------------------------------------------------
// alu_control
//   Registered ALU control decoder for the ID/EX stage of a 32-bit pipelined
//   MIPS-style datapath. Maps the main-control class (alu_op) and the R-type
//   funct field to a 4-bit ALU select, flagging undefined encodings.
//   One clock of latency; out_valid marks a cycle carrying an accepted input.
//
//   Configuration macro: ALU_CTRL_SHIFT_EN
//     defined   -> R-type sll/srl/sra decode to 1000/1001/1010
//     undefined -> those funct codes are illegal like any other unknown funct
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst_n         in   1  synchronous active-low reset
//   in_valid      in   1  alu_op/funct valid this cycle
//   alu_op        in   2  00 ld/st, 01 branch, 10 R-type, 11 reserved
//   funct         in   6  instruction[5:0], used only for R-type
//   alu_ctrl_out  out  4  registered ALU operation select
//   out_valid     out  1  outputs correspond to an accepted input
//   illegal       out  1  registered undefined-encoding flag
// ---------------------------------------------------------------------------
module alu_control #(
   parameter logic [3:0] ILLEGAL_CODE = 4'b0010
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl_out,
   output logic       out_valid,
   output logic       illegal
);

   localparam int unsigned OP_W    = 2;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned CTRL_W  = 4;

   localparam logic [OP_W-1:0] OP_MEM    = 2'b00;
   localparam logic [OP_W-1:0] OP_BRANCH = 2'b01;
   localparam logic [OP_W-1:0] OP_RTYPE  = 2'b10;

   localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
   localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
   localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
   localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
   localparam logic [FUNCT_W-1:0] F_NOR = 6'b100111;
   localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;
`ifdef ALU_CTRL_SHIFT_EN
   localparam logic [FUNCT_W-1:0] F_SLL = 6'b000000;
   localparam logic [FUNCT_W-1:0] F_SRL = 6'b000010;
   localparam logic [FUNCT_W-1:0] F_SRA = 6'b000011;
`endif

   localparam logic [CTRL_W-1:0] C_ADD = 4'b0010;
   localparam logic [CTRL_W-1:0] C_SUB = 4'b0110;
   localparam logic [CTRL_W-1:0] C_AND = 4'b0000;
   localparam logic [CTRL_W-1:0] C_OR  = 4'b0001;
   localparam logic [CTRL_W-1:0] C_NOR = 4'b1100;
   localparam logic [CTRL_W-1:0] C_SLT = 4'b0111;
`ifdef ALU_CTRL_SHIFT_EN
   localparam logic [CTRL_W-1:0] C_SLL = 4'b1000;
   localparam logic [CTRL_W-1:0] C_SRL = 4'b1001;
   localparam logic [CTRL_W-1:0] C_SRA = 4'b1010;
`endif

   logic [CTRL_W-1:0] dec_ctrl_c;
   logic              dec_illegal_c;

   logic [CTRL_W-1:0] alu_ctrl_d, alu_ctrl_q;
   logic              out_valid_d, out_valid_q;
   logic              illegal_d, illegal_q;

   // Pure combinational decode; unknown encodings fall back to the safe code.
   always_comb begin
      dec_ctrl_c    = ILLEGAL_CODE;
      dec_illegal_c = 1'b1;
      case (alu_op)
         OP_MEM: begin
            dec_ctrl_c    = C_ADD;
            dec_illegal_c = 1'b0;
         end
         OP_BRANCH: begin
            dec_ctrl_c    = C_SUB;
            dec_illegal_c = 1'b0;
         end
         OP_RTYPE: begin
            dec_illegal_c = 1'b0;
            case (funct)
               F_ADD:   dec_ctrl_c = C_ADD;
               F_SUB:   dec_ctrl_c = C_SUB;
               F_AND:   dec_ctrl_c = C_AND;
               F_OR:    dec_ctrl_c = C_OR;
               F_NOR:   dec_ctrl_c = C_NOR;
               F_SLT:   dec_ctrl_c = C_SLT;
`ifdef ALU_CTRL_SHIFT_EN
               F_SLL:   dec_ctrl_c = C_SLL;
               F_SRL:   dec_ctrl_c = C_SRL;
               F_SRA:   dec_ctrl_c = C_SRA;
`endif
               default: begin
                  dec_ctrl_c    = ILLEGAL_CODE;
                  dec_illegal_c = 1'b1;
               end
            endcase
         end
         default: begin
            dec_ctrl_c    = ILLEGAL_CODE;
            dec_illegal_c = 1'b1;
         end
      endcase
   end

   // Capture a new result only on accepted inputs; otherwise hold and drop valid.
   always_comb begin
      alu_ctrl_d  = alu_ctrl_q;
      illegal_d   = illegal_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         alu_ctrl_d  = dec_ctrl_c;
         illegal_d   = dec_illegal_c;
         out_valid_d = 1'b1;
      end
   end

   // Output registers with synchronous reset taking priority over in_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_ctrl_q  <= CTRL_W'(0);
         out_valid_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         alu_ctrl_q  <= alu_ctrl_d;
         out_valid_q <= out_valid_d;
         illegal_q   <= illegal_d;
      end
   end

   assign alu_ctrl_out = alu_ctrl_q;
   assign out_valid    = out_valid_q;
   assign illegal      = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// ---------------------------------------------------------------------------
// tb_alu_control
//   Directed steps followed by randomized traffic against a table-driven
//   reference model of the ALU control decoder. Honors ALU_CTRL_SHIFT_EN.
// ---------------------------------------------------------------------------
module tb_alu_control;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] alu_op;
   logic [5:0] funct;
   logic [3:0] alu_ctrl_out;
   logic       out_valid;
   logic       illegal;

   int errors = 0;
   int checks = 0;

   // Reference state: what the outputs should be after the latest edge.
   logic [3:0] exp_ctrl;
   logic       exp_valid;
   logic       exp_ill;

   // Table of defined R-type funct codes and their ALU selects.
   logic [5:0] rt_funct[$];
   logic [3:0] rt_code[$];

   alu_control dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .alu_op       (alu_op),
      .funct        (funct),
      .alu_ctrl_out (alu_ctrl_out),
      .out_valid    (out_valid),
      .illegal      (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void ref_decode(input logic [1:0] op, input logic [5:0] f,
                                      output logic [3:0] code, output logic ill);
      code = 4'b0010;
      ill  = 1'b1;
      if (op == 2'd0) begin
         code = 4'b0010; ill = 1'b0;
      end else if (op == 2'd1) begin
         code = 4'b0110; ill = 1'b0;
      end else if (op == 2'd2) begin
         foreach (rt_funct[i]) begin
            if (rt_funct[i] == f) begin
               code = rt_code[i];
               ill  = 1'b0;
            end
         end
      end
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Apply one cycle of inputs, advance the model, and compare all outputs.
   task automatic step(input logic r, input logic v, input logic [1:0] op, input logic [5:0] f);
      logic [3:0] c;
      logic       il;
      rst_n    = r;
      in_valid = v;
      alu_op   = op;
      funct    = f;
      @(posedge clk);
      if (!r) begin
         exp_ctrl = 4'b0000; exp_valid = 1'b0; exp_ill = 1'b0;
      end else if (v) begin
         ref_decode(op, f, c, il);
         exp_ctrl = c; exp_valid = 1'b1; exp_ill = il;
      end else begin
         exp_valid = 1'b0;
      end
      #1;
      check("alu_ctrl_out", alu_ctrl_out, exp_ctrl);
      check("out_valid", 4'(out_valid), 4'(exp_valid));
      check("illegal", 4'(illegal), 4'(exp_ill));
      @(negedge clk);
   endtask

   initial begin
      logic [5:0] sweep_f[6];
      logic [3:0] sweep_c[6];
      logic [5:0] rf;

      rt_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
      rt_code  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
`ifdef ALU_CTRL_SHIFT_EN
      rt_funct.push_back(6'b000000); rt_code.push_back(4'b1000);
      rt_funct.push_back(6'b000010); rt_code.push_back(4'b1001);
      rt_funct.push_back(6'b000011); rt_code.push_back(4'b1010);
`endif
      exp_ctrl = 4'b0000; exp_valid = 1'b0; exp_ill = 1'b0;

      // Reset held for two edges with a valid input presented.
      step(1'b0, 1'b1, 2'b10, 6'b100010);
      step(1'b0, 1'b1, 2'b10, 6'b100010);
      check("rst_ctrl_lit", alu_ctrl_out, 4'b0000);
      check("rst_valid_lit", 4'(out_valid), 4'd0);

      // Fixed classes.
      step(1'b1, 1'b1, 2'b00, 6'b000000);
      check("ldst_lit", alu_ctrl_out, 4'b0010);
      step(1'b1, 1'b1, 2'b01, 6'b100000);
      check("branch_lit", alu_ctrl_out, 4'b0110);

      // Back-to-back R-type sweep.
      sweep_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
      sweep_c = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 2'b10, sweep_f[i]);
         check("rtype_lit", alu_ctrl_out, sweep_c[i]);
         check("rtype_valid_lit", 4'(out_valid), 4'd1);
      end

      // Illegal encodings.
      step(1'b1, 1'b1, 2'b11, 6'b100000);
      check("op11_ill_lit", 4'(illegal), 4'd1);
      step(1'b1, 1'b1, 2'b10, 6'b111111);
      check("badfunct_ill_lit", 4'(illegal), 4'd1);
      check("badfunct_code_lit", alu_ctrl_out, 4'b0010);

      // Hold on in_valid=0.
      step(1'b1, 1'b1, 2'b10, 6'b100000);
      step(1'b1, 1'b0, 2'b10, 6'b100101);
      check("hold_ctrl_lit", alu_ctrl_out, 4'b0010);
      check("hold_valid_lit", 4'(out_valid), 4'd0);

      // Shift decode depends on build option.
      step(1'b1, 1'b1, 2'b10, 6'b000010);
`ifdef ALU_CTRL_SHIFT_EN
      check("srl_lit", alu_ctrl_out, 4'b1001);
      check("srl_ill_lit", 4'(illegal), 4'd0);
`else
      check("srl_lit", alu_ctrl_out, 4'b0010);
      check("srl_ill_lit", 4'(illegal), 4'd1);
`endif

      // Reset mid-stream, then a normal result right after release.
      step(1'b0, 1'b1, 2'b01, 6'b000000);
      step(1'b1, 1'b1, 2'b10, 6'b100111);
      check("post_rst_lit", alu_ctrl_out, 4'b1100);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(1, 0) == 1) rf = rt_funct[$urandom_range(rt_funct.size() - 1, 0)];
         else if ($urandom_range(3, 0) == 0) rf = 6'($urandom_range(3, 0));
         else rf = 6'($urandom);
         step(($urandom_range(19, 0) != 0), ($urandom_range(3, 0) != 0),
              2'($urandom), rf);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_control.md
Name: alu_control

Overview:
- Registered ALU control decoder for the 32-bit pipelined MIPS-style datapath; sits in the ID/EX stage between the main control unit and the ALU.
- Maps the 2-bit alu_op from main control, plus the 6-bit R-type funct field, to a 4-bit ALU operation select.
- Flags undefined encodings.
- Output is registered: one clock of latency with a valid qualifier.

Parameters:
- ILLEGAL_CODE, 4'b0010, ALU select driven when the encoding is undefined (safe ADD).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  alu_op/funct valid this cycle
- alu_op  input  2  class from main control: 00 load/store, 01 branch, 10 R-type, 11 reserved
- funct  input  6  instruction[5:0]; used only when alu_op=10
- alu_ctrl_out  output  4  registered ALU operation select
- out_valid  output  1  alu_ctrl_out/illegal correspond to an accepted input
- illegal  output  1  registered flag: undefined alu_op/funct combination

Behaviour:
- Reset: all outputs are updated only on the rising clk edge. When rst_n=0 at an edge, the outputs become alu_ctrl_out=4'b0000, out_valid=0, illegal=0. Reset takes priority over in_valid, and an input presented in the same cycle is dropped.
- Latency: inputs sampled at edge N with in_valid=1 appear at alu_ctrl_out/illegal after edge N, with out_valid=1 for exactly that cycle.
  - Back-to-back valid inputs are accepted every cycle.
  - There is no backpressure.
- When in_valid=0 at an edge: out_valid goes to 0, and alu_ctrl_out and illegal hold their previous values.
- Decode, with the next-state function purely combinational on alu_op/funct:
  - alu_op=00 -> 4'b0010 (ADD); funct ignored.
  - alu_op=01 -> 4'b0110 (SUB); funct ignored.
  - alu_op=10, funct=100000 (add) -> 0010
  - alu_op=10, funct=100010 (sub) -> 0110
  - alu_op=10, funct=100100 (and) -> 0000
  - alu_op=10, funct=100101 (or) -> 0001
  - alu_op=10, funct=100111 (nor) -> 1100
  - alu_op=10, funct=101010 (slt) -> 0111
  - alu_op=10, any other funct -> ILLEGAL_CODE, illegal=1.
  - alu_op=11 -> ILLEGAL_CODE, illegal=1.
- illegal=0 for every defined combination.
- No X propagation: every alu_op/funct combination yields a defined output. A default branch is required.
- Reset deasserting mid-stream: the first edge with rst_n=1 and in_valid=1 produces a normal result at the next cycle.

Optional Feature:
- Macro ALU_CTRL_SHIFT_EN.
- Defined: alu_op=10 additionally decodes:
  - funct=000000 (sll) -> 1000
  - funct=000010 (srl) -> 1001
  - funct=000011 (sra) -> 1010
  - illegal=0 for these three.
- Undefined: those three funct codes are illegal (ILLEGAL_CODE, illegal=1). All other behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 edges with in_valid=1, alu_op=10, funct=100010 -> alu_ctrl_out=0000, out_valid=0, illegal=0.
- Fixed classes:
  - in_valid=1, alu_op=00, funct=000000 -> next cycle alu_ctrl_out=0010, out_valid=1.
  - alu_op=01, funct=100000 -> 0110.
- R-type sweep, back-to-back with alu_op=10, one per cycle:
  - funct 100000/100010/100100/100101/100111/101010 -> 0010/0110/0000/0001/1100/0111 on consecutive cycles, illegal=0.
- Illegal cases:
  - alu_op=11, funct=100000 -> 0010, illegal=1.
  - alu_op=10, funct=111111 -> 0010, illegal=1.
- Hold: valid add, then in_valid=0 with alu_op=10, funct=100101 -> out_valid=0, alu_ctrl_out stays 0010.
- Shift:
  - alu_op=10, funct=000010 -> 1001, illegal=0 with ALU_CTRL_SHIFT_EN.
  - Same stimulus -> 0010, illegal=1 without it.
